apb_req_master: RTL
===================

// Module: apb_req_master
// PURPOSE
// - Initiator end of the APB_BUS interface; drives the Master modport.
// - Converts a valid/ready request/response stream into compliant APB SETUP/ACCESS transfers.
// - Sits between the core-side request/response bus and the peripheral APB fabric.
// - Issues one transfer at a time; back-to-back transfers are supported with no idle cycle.
// PARAMETERS
// - APB_ADDR_WIDTH  32   width of paddr and req_addr_i
// - APB_DATA_WIDTH  32   width of pwdata/prdata, req_wdata_i and rsp_rdata_o
// - TIMEOUT_CYCLES  256  ACCESS cycles allowed without pready; only used with APB_TIMEOUT_EN
// PORTS
// - HCLK         in   1      clock; all logic is on the rising edge
// - HRESETn      in   1      asynchronous reset, active low
// - req_valid_i  in   1      request present
// - req_ready_o  out  1      request accepted when high together with req_valid_i
// - req_addr_i   in   AW     byte address of the transfer
// - req_wdata_i  in   DW     write data
// - req_write_i  in   1      1 = write, 0 = read
// - rsp_valid_o  out  1      response present
// - rsp_ready_i  in   1      response consumed when high together with rsp_valid_o
// - rsp_rdata_o  out  DW     read data; 0 for writes and for errors
// - rsp_err_o    out  1      pslverr, misalignment or timeout
// - apb_master   intf APB_BUS.Master  paddr/pwdata/pwrite/psel/penable out; prdata/pready/pslverr in
// BEHAVIOUR
// - Reset (async, HRESETn=0): state IDLE; psel, penable, pwrite = 0; paddr, pwdata = 0;
//   rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, req_ready_o = 0.
//   psel/penable drop immediately, even mid-transfer; the in-flight request is lost.
// - FSM states: IDLE, SETUP, ACCESS, RESP.
// - req_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i); combinational; 0 while in reset.
// - IDLE/RESP, request accepted:
//   - Aligned (addr[1:0]==0): latch paddr/pwdata/pwrite -> SETUP (psel=1, penable=0).
//   - Misaligned: no APB activity -> RESP with rsp_err_o=1, rsp_rdata_o=0.
// - SETUP -> ACCESS unconditionally after one cycle (psel=1, penable=1).
// - ACCESS:
//   - pready=0: hold in ACCESS.
//   - pready=1: capture rdata (prdata on read, 0 on write) and rsp_err_o=pslverr
//     -> RESP with psel=0 and penable=0.
// - paddr/pwdata/pwrite stay stable from SETUP through ACCESS and keep their values afterwards.
// - RESP: rsp_valid_o=1 and the response is held stable until rsp_ready_i.
//   - rsp_ready_i=1, no new request: -> IDLE.
//   - rsp_ready_i=1 with a new request: -> SETUP (or RESP if misaligned) in the same cycle.
// - Latency: accept at cycle N, SETUP at N+1, ACCESS at N+2; with pready at N+2, rsp_valid_o=1 at N+3.
//   Best-case throughput is one transfer per 3 cycles.
// - rsp_valid_o never asserts while psel=1; only one transfer is outstanding at any time.
// CONFIGURATION
// - APB_TIMEOUT_EN defined:
//   - A wait counter clears on SETUP and increments each ACCESS cycle with pready=0.
//   - When the count equals TIMEOUT_CYCLES-1 and pready=0: -> RESP with rsp_err_o=1 and
//     rsp_rdata_o=0; psel and penable deassert.
//   - pready arriving in that same cycle wins (normal completion).
// - APB_TIMEOUT_EN undefined: no counter and no TIMEOUT_CYCLES logic; ACCESS waits for
//   pready indefinitely.
// STRUCTURE
// - Package apb_master_pkg:
//   - apb_mst_state_e enum {IDLE, SETUP, ACCESS, RESP}.
//   - apb_rsp_t struct {rdata, err}.
//   - localparam TO_CNT_W = $clog2(TIMEOUT_CYCLES).
// - Sub-module apb_timeout_cnt (clear, enable, expired): instantiated only under APB_TIMEOUT_EN.
// - FSM and datapath registers stay in apb_req_master.
// TESTING
// - Write to 0x1A10_0000, data 0xCAFE_F00D, pready=1 at first ACCESS:
//   - psel rises 1 cycle after accept; penable rises 1 cycle later.
//   - rsp_valid_o=1 with rsp_err_o=0 and rsp_rdata_o=0, 3 cycles after accept.
// - Read from 0x1A10_0004, slave holds pready=0 for 5 cycles then returns prdata=0x1234_5678:
//   - paddr stable for all ACCESS cycles; rsp_rdata_o=0x1234_5678.
// - Read with pslverr=1: rsp_err_o=1; rsp_valid_o holds while rsp_ready_i=0 for 4 cycles.
// - Request at address 0x1A10_0002: psel never asserts; rsp_err_o=1 on the cycle after accept.
// - Back-to-back:
//   - Two writes with rsp_ready_i=1 tied high: second SETUP in the cycle after the first RESP.
//   - HRESETn pulsed low during ACCESS: psel/penable=0 at once; bus idle after release.
// - With APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready held at 0:
//   - rsp_err_o=1 after 8 ACCESS cycles; psel=0 on the following cycle.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and helpers for the APB request master.
// The APB_TIMEOUT_EN build sizes its wait counter with to_cnt_w().
package apb_master_pkg;

    localparam int unsigned APB_DW              = 32;
    localparam int unsigned TIMEOUT_CYCLES_DFLT = 256;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_e;

    typedef struct packed {
        logic [APB_DW-1:0] rdata;
        logic              err;
    } apb_rsp_t;

    // Keeps the counter at least one bit wide for degenerate timeouts.
    function automatic int unsigned to_cnt_w(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int unsigned TO_CNT_W = to_cnt_w(TIMEOUT_CYCLES_DFLT);

endpackage

// File: rtl/apb_bus.sv
// APB bus bundle; the Master modport drives the request side.
interface APB_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait counter, only instantiated when APB_TIMEOUT_EN is defined.
// expired flags the last allowed wait cycle.
module apb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 8
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_req_master.sv
// Valid/ready request stream to APB SETUP/ACCESS master, one transfer in flight.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_req_master
    import apb_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = APB_DW,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    input  logic                      req_write_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    APB_BUS.Master                    apb_master
);

    apb_mst_state_e            state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    apb_rsp_t                  rsp_q, rsp_d;
    logic                      accept;
    logic                      timed_out;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = to_cnt_w(TIMEOUT_CYCLES);

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CntW)
    ) u_timeout_cnt (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clear   (state_q == SETUP),
        .enable  ((state_q == ACCESS) && !apb_master.pready),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
    // TIMEOUT_CYCLES has no effect without the timeout counter.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
    end
`endif

    // Gated with reset so no request is accepted while the block is held in reset.
    assign req_ready_o = HRESETn &
                         ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rsp_d    = rsp_q;

        unique case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (req_addr_i[1:0] == 2'b00) begin
                        paddr_d  = req_addr_i;
                        pwdata_d = req_wdata_i;
                        pwrite_d = req_write_i;
                        state_d  = SETUP;
                    end else begin
                        rsp_d   = '{rdata: '0, err: 1'b1};
                        state_d = RESP;
                    end
                end else if ((state_q == RESP) && rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (apb_master.pready) begin
                    rsp_d.err   = apb_master.pslverr;
                    rsp_d.rdata = (pwrite_q || apb_master.pslverr) ? '0 : apb_master.prdata;
                    state_d     = RESP;
                end else if (timed_out) begin
                    rsp_d   = '{rdata: '0, err: 1'b1};
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rsp_q    <= rsp_d;
        end
    end

    assign apb_master.paddr   = paddr_q;
    assign apb_master.pwdata  = pwdata_q;
    assign apb_master.pwrite  = pwrite_q;
    assign apb_master.psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign apb_master.penable = (state_q == ACCESS);

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_rdata_o = rsp_q.rdata;
    assign rsp_err_o   = rsp_q.err;

endmodule
